lmt_stats_collector: RTL and testbench

- Parametrised successor to the per-LMT search/match statistics monitor.
- Keeps saturating per-LMT search, match and miss counters plus pipeline-wide totals.
- Totals are popcount-accurate: several LMTs hitting in the same cycle all count.
- Adds an atomic snapshot bank, a registered CSR-style read port with clear-on-read, and sticky overflow flags; the control plane polls it from beside the MAU chain.

---
 rtl/lmt_stats_collector.sv | 124 ++++++++++++
 tb/tb_lmt_stats_collector.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/lmt_stats_collector.sv
// lmt_stats_collector: saturating per-LMT search/match/miss counters with totals, snapshot bank and CSR read port
module lmt_stats_collector #(
    parameter int NUM_LMTS  = 5,
    parameter int CNT_WIDTH = 32,
    parameter int IDX_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_count_en,
    input  logic [NUM_LMTS-1:0]  lmt_used,
    input  logic [NUM_LMTS-1:0]  lmt_search_en,
    input  logic [NUM_LMTS-1:0]  lmt_result_valid,
    input  logic [NUM_LMTS-1:0]  lmt_match_found,
    input  logic                 clr_all,
    input  logic                 snap_req,
    input  logic                 rd_req,
    input  logic                 rd_bank,
    input  logic [IDX_WIDTH-1:0] rd_idx,
    input  logic [1:0]           rd_sel,
    input  logic                 rd_clr,
    output logic                 rd_valid,
    output logic [CNT_WIDTH-1:0] rd_data,
    output logic                 rd_err,
    output logic [NUM_LMTS-1:0]  ovf_flags,
    output logic                 snap_valid
);
    localparam int N = NUM_LMTS + 1;
    localparam logic [IDX_WIDTH-1:0] TOT = IDX_WIDTH'(NUM_LMTS);
    localparam logic [CNT_WIDTH-1:0] MAX = '1;

    logic [CNT_WIDTH-1:0] live_q [3][N];
    logic [CNT_WIDTH-1:0] live_d [3][N];
    logic [CNT_WIDTH-1:0] snap_q [3][N];
    logic [CNT_WIDTH-1:0] snap_d [3][N];
    logic [CNT_WIDTH-1:0] incv   [3][N];
    logic                 sat    [3][N];
    logic [NUM_LMTS-1:0]  ev     [3];
    logic [NUM_LMTS-1:0]  q, ovf_q, ovf_d;
    logic [CNT_WIDTH:0]   sum;
    logic                 snap_valid_q, snap_valid_d, rd_valid_q, rd_valid_d, rd_err_q, rd_err_d;
    logic [CNT_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                 idx_ok, clr_cnt;

    always_comb begin
        q = {NUM_LMTS{cfg_count_en}} & lmt_used;
        ev[0] = q & lmt_search_en;
        ev[1] = q & lmt_result_valid & lmt_match_found;
        ev[2] = q & lmt_result_valid & ~lmt_match_found;
        idx_ok = rd_idx <= TOT;
        clr_cnt = rd_req & rd_clr & ~rd_bank & (rd_sel != 2'd3) & idx_ok;
        live_d = live_q;
        ovf_d = ovf_q;
        sum = '0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NUM_LMTS; i++) incv[k][i] = CNT_WIDTH'(ev[k][i]);
            incv[k][NUM_LMTS] = CNT_WIDTH'($countones(ev[k]));
        end
        for (int i = 0; i < NUM_LMTS; i++)
            if (rd_req && rd_clr && rd_sel == 2'd3 && rd_idx == IDX_WIDTH'(i)) ovf_d[i] = 1'b0;
        // a clear-on-read hit reloads with this cycle's increment so no event is lost
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++) begin
                sum = {1'b0, live_q[k][i]} + {1'b0, incv[k][i]};
                sat[k][i] = 1'b0;
                if (clr_cnt && rd_sel == 2'(k) && rd_idx == IDX_WIDTH'(i)) begin
                    live_d[k][i] = incv[k][i];
                end else begin
                    live_d[k][i] = sum[CNT_WIDTH] ? MAX : sum[CNT_WIDTH-1:0];
                    sat[k][i] = sum[CNT_WIDTH];
                end
            end
            for (int i = 0; i < NUM_LMTS; i++) ovf_d[i] = ovf_d[i] | sat[k][i];
        end
        if (clr_all) begin
            for (int k = 0; k < 3; k++)
                for (int i = 0; i < N; i++) live_d[k][i] = '0;
            ovf_d = '0;
        end
        snap_d = snap_req ? live_q : snap_q;
        snap_valid_d = ~clr_all & (snap_req | snap_valid_q);
        rd_valid_d = rd_req;
        rd_err_d = rd_req & ~idx_ok;
        rd_data_d = rd_req ? '0 : rd_data_q;
        if (rd_req) begin
            for (int k = 0; k < 3; k++)
                for (int i = 0; i < N; i++)
                    if (rd_sel == 2'(k) && rd_idx == IDX_WIDTH'(i)) rd_data_d = rd_bank ? snap_q[k][i] : live_q[k][i];
            if (rd_sel == 2'd3) begin
                rd_data_d = (rd_idx == TOT) ? CNT_WIDTH'(|ovf_q) : '0;
                for (int i = 0; i < NUM_LMTS; i++)
                    if (rd_idx == IDX_WIDTH'(i)) rd_data_d = CNT_WIDTH'({lmt_used[i], ovf_q[i]});
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++)
                for (int i = 0; i < N; i++) begin
                    live_q[k][i] <= '0;
                    snap_q[k][i] <= '0;
                end
            ovf_q <= '0;
            snap_valid_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_err_q <= 1'b0;
            rd_data_q <= '0;
        end else begin
            live_q <= live_d;
            snap_q <= snap_d;
            ovf_q <= ovf_d;
            snap_valid_q <= snap_valid_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q <= rd_err_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data = rd_data_q;
    assign rd_err = rd_err_q;
    assign ovf_flags = ovf_q;
    assign snap_valid = snap_valid_q;
endmodule

// File: tb/tb_lmt_stats_collector.sv
// tb_lmt_stats_collector: directed test-plan checks plus randomized run against a behavioural model
module tb_lmt_stats_collector;
    logic       clk = 0, rst = 1, cfg_count_en = 0, clr_all = 0, snap_req = 0;
    logic       rd_req = 0, rd_bank = 0, rd_clr = 0;
    logic [4:0] lmt_used = 0, lmt_search_en = 0, lmt_result_valid = 0, lmt_match_found = 0;
    logic [2:0] rd_idx = 0;
    logic [1:0] rd_sel = 0;
    logic       rd_valid, rd_err, snap_valid;
    logic [7:0] rd_data;
    logic [4:0] ovf_flags;
    int tests = 0, fails = 0;
    bit chk_en = 0;

    lmt_stats_collector #(.NUM_LMTS(5), .CNT_WIDTH(8), .IDX_WIDTH(3)) dut (
        .clk(clk), .rst(rst), .cfg_count_en(cfg_count_en), .lmt_used(lmt_used),
        .lmt_search_en(lmt_search_en), .lmt_result_valid(lmt_result_valid),
        .lmt_match_found(lmt_match_found), .clr_all(clr_all), .snap_req(snap_req),
        .rd_req(rd_req), .rd_bank(rd_bank), .rd_idx(rd_idx), .rd_sel(rd_sel), .rd_clr(rd_clr),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err), .ovf_flags(ovf_flags),
        .snap_valid(snap_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // behavioural model: counters as plain ints, clamped at 255
    int ml [3][6];
    int ms [3][6];
    bit [4:0] mo;
    bit msv, e_valid, e_err;
    int e_data;

    always @(posedge clk) begin
        int inc [3][6];
        int v;
        if (rst) begin
            foreach (ml[k, i]) begin ml[k][i] = 0; ms[k][i] = 0; end
            mo = 0; msv = 0; e_valid = 0; e_err = 0; e_data = 0;
        end else begin
            e_valid = rd_req;
            e_err = 0;
            if (rd_req) begin
                if (rd_idx > 5) begin e_data = 0; e_err = 1; end
                else if (rd_sel == 3) e_data = (rd_idx == 5) ? int'(|mo) : 2 * lmt_used[rd_idx] + mo[rd_idx];
                else e_data = rd_bank ? ms[rd_sel][rd_idx] : ml[rd_sel][rd_idx];
            end
            if (snap_req) ms = ml;
            for (int k = 0; k < 3; k++) inc[k][5] = 0;
            for (int i = 0; i < 5; i++) begin
                bit qq;
                qq = cfg_count_en & lmt_used[i];
                inc[0][i] = int'(qq & lmt_search_en[i]);
                inc[1][i] = int'(qq & lmt_result_valid[i] & lmt_match_found[i]);
                inc[2][i] = int'(qq & lmt_result_valid[i] & !lmt_match_found[i]);
                for (int k = 0; k < 3; k++) inc[k][5] += inc[k][i];
            end
            if (rd_req && rd_clr && rd_sel == 3 && rd_idx < 5) mo[rd_idx] = 0;
            for (int k = 0; k < 3; k++)
                for (int i = 0; i < 6; i++) begin
                    if (rd_req && rd_clr && !rd_bank && int'(rd_sel) == k && int'(rd_idx) == i) ml[k][i] = inc[k][i];
                    else begin
                        v = ml[k][i] + inc[k][i];
                        if (v > 255) begin v = 255; if (i < 5) mo[i] = 1; end
                        ml[k][i] = v;
                    end
                end
            msv = msv | snap_req;
            if (clr_all) begin
                foreach (ml[k, i]) ml[k][i] = 0;
                mo = 0; msv = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rd_valid", int'(rd_valid), int'(e_valid));
            chk("rd_err", int'(rd_err), int'(e_err));
            chk("rd_data", int'(rd_data), e_data);
            chk("ovf_flags", int'(ovf_flags), int'(mo));
            chk("snap_valid", int'(snap_valid), int'(msv));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input int idx, input int sel, input int bank, input int clr, output int data, output int err);
        rd_req = 1; rd_idx = 3'(idx); rd_sel = 2'(sel); rd_bank = 1'(bank); rd_clr = 1'(clr);
        @(negedge clk);
        rd_req = 0; rd_clr = 0;
        chk("rd_pulse", int'(rd_valid), 1);
        data = int'(rd_data);
        err = int'(rd_err);
    endtask

    initial begin
        int d, e;
        step(2);
        chk_en = 1;
        chk("rst_valid", int'(rd_valid), 0);
        chk("rst_data", int'(rd_data), 0);
        chk("rst_ovf", int'(ovf_flags), 0);
        chk("rst_snapv", int'(snap_valid), 0);
        rst = 0;
        cfg_count_en = 1; lmt_used = 5'b11111; lmt_search_en = 5'b10101;
        step(4);
        lmt_search_en = 0;
        rd(0, 0, 0, 0, d, e); chk("lmt0_search", d, 4);
        step(1); chk("rd_valid_drop", int'(rd_valid), 0);
        rd(1, 0, 0, 0, d, e); chk("lmt1_search", d, 0);
        rd(5, 0, 0, 0, d, e); chk("tot_search", d, 12);
        lmt_result_valid = 5'b00100; lmt_match_found = 5'b00100;
        step(3);
        lmt_match_found = 0; step(2);
        lmt_match_found = 5'b00100; lmt_used = 5'b11011; step(1);
        lmt_result_valid = 0; lmt_match_found = 0; lmt_used = 5'b11111;
        rd(2, 1, 0, 0, d, e); chk("lmt2_match", d, 3);
        rd(2, 2, 0, 0, d, e); chk("lmt2_miss", d, 2);
        rd(5, 1, 0, 0, d, e); chk("tot_match", d, 3);
        lmt_search_en = 5'b00001; step(300); lmt_search_en = 0;
        rd(0, 0, 0, 0, d, e); chk("lmt0_sat", d, 255);
        chk("ovf0_set", int'(ovf_flags[0]), 1);
        lmt_used = 5'b11110;
        rd(0, 3, 0, 1, d, e); chk("status_rd", d, 1);
        chk("ovf0_clr", int'(ovf_flags[0]), 0);
        lmt_used = 5'b11111;
        rd(0, 0, 0, 1, d, e); chk("clr_old", d, 255);
        lmt_search_en = 5'b00001; step(3);
        rd(0, 0, 0, 1, d, e); chk("clr_same_cyc", d, 3);
        lmt_search_en = 0;
        rd(0, 0, 0, 0, d, e); chk("clr_kept_event", d, 1);
        lmt_search_en = 5'b01000; step(7); lmt_search_en = 0;
        snap_req = 1; step(1); snap_req = 0;
        chk("snapv_set", int'(snap_valid), 1);
        lmt_search_en = 5'b01000; step(5); lmt_search_en = 0;
        clr_all = 1; step(1); clr_all = 0;
        chk("snapv_clr", int'(snap_valid), 0);
        rd(3, 0, 1, 0, d, e); chk("snap_lmt3", d, 7);
        rd(3, 0, 0, 0, d, e); chk("live_lmt3", d, 0);
        rd(7, 0, 0, 1, d, e); chk("bad_idx_data", d, 0); chk("bad_idx_err", e, 1);
        rd_req = 1; rst = 1; step(1); rd_req = 0;
        chk("rst_suppress", int'(rd_valid), 0);
        rst = 0;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom % 500) == 0;
            cfg_count_en = ($urandom % 8) != 0;
            lmt_used = 5'($urandom);
            lmt_search_en = 5'($urandom);
            lmt_result_valid = 5'($urandom);
            lmt_match_found = 5'($urandom);
            clr_all = ($urandom % 200) == 0;
            snap_req = ($urandom % 16) == 0;
            rd_req = $urandom % 2;
            rd_bank = $urandom % 2;
            rd_idx = 3'($urandom);
            rd_sel = 2'($urandom);
            rd_clr = ($urandom % 4) == 0;
            step(1);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
